// File: rtl/viking_prefetch.sv
`timescale 1ns/1ps
// Read-ahead FIFO feeding the Viking mono shifter: issues credit-limited 64-bit reads in free bus slots.
// Latency mem_slot->word_valid = RAM latency + 1; reads stall when stored+in-flight reach depth. Option: VIKING_UNDERRUN_CNT_EN.
module viking_prefetch #(
    parameter int          DEPTH_LOG2  = 3,
    parameter logic [22:0] BASE        = 23'h600000,
    parameter logic [22:0] BASE_HI     = 23'h740000,
    parameter int          FRAME_WORDS = 20480
) (
    input  logic                  pclk_i,
    input  logic                  reset_n_i,
    input  logic                  himem_i,
    input  logic                  frame_start_i,
    input  logic                  mem_slot_i,
    output logic [22:0]           addr_o,
    output logic                  read_o,
    input  logic [63:0]           data_i,
    input  logic                  data_valid_i,
    input  logic                  pop_i,
    output logic [63:0]           word_out_o,
    output logic                  word_valid_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  underrun_o
`ifdef VIKING_UNDERRUN_CNT_EN
    ,
    output logic [15:0]           underrun_cnt_o
`endif
);

    localparam int              DEPTH   = 2**DEPTH_LOG2;
    localparam int              CW      = DEPTH_LOG2 + 1;
    localparam int              IW      = $clog2(FRAME_WORDS + 1);
    localparam logic [CW:0]     DEPTH_V = (CW+1)'(DEPTH);
    localparam logic [IW-1:0]   FRAME_V = IW'(FRAME_WORDS);

    logic [22:0]           addr_q, addr_d;
    logic [IW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         outstanding_q, outstanding_d;
    logic [7:0]            drop_q, drop_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         level_q, level_d;
    logic                  underrun_q, underrun_d;
    logic [63:0]           mem_q [DEPTH];
    logic [63:0]           head;

    logic credit_ok, ret_drop, push, do_pop, empty_pop;

    // Credit covers both stored and in-flight words, so a return can never find the FIFO full.
    assign credit_ok = ({1'b0, level_q} + {1'b0, outstanding_q}) < DEPTH_V;
    assign read_o    = reset_n_i & mem_slot_i & (issued_q < FRAME_V) & credit_ok;
    assign ret_drop  = data_valid_i & (drop_q != 8'd0);
    assign push      = data_valid_i & (drop_q == 8'd0) & (outstanding_q != '0);
    assign do_pop    = pop_i & (level_q != '0);
    assign empty_pop = pop_i & (level_q == '0);

    always_comb begin
        addr_d        = addr_q;
        issued_d      = issued_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        underrun_d    = underrun_q;
        if (frame_start_i) begin
            // Everything still owed by RAM for the old frame, including this cycle's read, gets discarded.
            addr_d        = himem_i ? BASE_HI : BASE;
            issued_d      = '0;
            outstanding_d = '0;
            drop_d        = drop_q - 8'(ret_drop) + 8'(outstanding_q) + 8'(read_o) - 8'(push);
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            level_d       = '0;
            underrun_d    = 1'b0;
        end else begin
            if (read_o) begin
                addr_d   = addr_q + 23'd4;
                issued_d = issued_q + IW'(1);
            end
            outstanding_d = outstanding_q + CW'(read_o) - CW'(push);
            drop_d        = drop_q - 8'(ret_drop);
            if (push)      wr_ptr_d   = wr_ptr_q + 1'b1;
            if (do_pop)    rd_ptr_d   = rd_ptr_q + 1'b1;
            level_d = level_q + CW'(push) - CW'(do_pop);
            if (empty_pop) underrun_d = 1'b1;
        end
    end

    always_ff @(posedge pclk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            addr_q        <= BASE;
            issued_q      <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            underrun_q    <= 1'b0;
        end else begin
            addr_q        <= addr_d;
            issued_q      <= issued_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            underrun_q    <= underrun_d;
        end
    end

    always_ff @(posedge pclk_i) begin
        if (push && !frame_start_i) mem_q[wr_ptr_q] <= data_i;
    end

    assign head         = mem_q[rd_ptr_q];
    assign word_valid_o = (level_q != '0);
    assign word_out_o   = word_valid_o ? {head[15:0], head[31:16], head[47:32], head[63:48]} : 64'd0;
    assign level_o      = level_q;
    assign addr_o       = addr_q;
    assign underrun_o   = underrun_q;

`ifdef VIKING_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q;

    always_ff @(posedge pclk_i or negedge reset_n_i) begin
        if (!reset_n_i)                           ucnt_q <= '0;
        else if (empty_pop && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 16'd1;
    end

    assign underrun_cnt_o = ucnt_q;
`endif

endmodule

// File: tb/tb_viking_prefetch.sv
`timescale 1ns/1ps
// Bench for viking_prefetch: latency-4 RAM model, word scoreboard, reorder vector table, frame/drop/reset sequences.
module tb_viking_prefetch;

    logic        pclk = 1'b0;
    logic        reset_n, himem, frame_start, mem_slot, read, data_valid, pop;
    logic        word_valid, underrun;
    logic [22:0] addr;
    logic [63:0] data, word_out;
    logic [3:0]  level;
`ifdef VIKING_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    always #5 pclk = ~pclk;

    viking_prefetch dut (
        .pclk_i(pclk), .reset_n_i(reset_n), .himem_i(himem), .frame_start_i(frame_start),
        .mem_slot_i(mem_slot), .addr_o(addr), .read_o(read), .data_i(data),
        .data_valid_i(data_valid), .pop_i(pop), .word_out_o(word_out),
        .word_valid_o(word_valid), .level_o(level), .underrun_o(underrun)
`ifdef VIKING_UNDERRUN_CNT_EN
        , .underrun_cnt_o(underrun_cnt)
`endif
    );

    typedef struct { logic [63:0] d; logic [63:0] exp; } vec_t;
    typedef struct { int due; logic [63:0] d; } ret_t;

    vec_t        vecs [4];
    ret_t        ret_q [$];
    logic [63:0] exp_q [$];
    logic [22:0] rd_addrs [$];
    int          tests = 0, fails = 0, cyc = 0, n_reads = 0, first_rd = -1, first_wv = -1;
    logic [22:0] last_addr = '0;
    bit          ram_en = 1'b1, sb_en = 1'b1, man_dv = 1'b0;
    logic [63:0] man_data = '0;

    function automatic logic [63:0] ramfn(input logic [22:0] a);
        return {9'h0A5, a, 9'h15A, ~a};
    endfunction

    function automatic logic [63:0] reorder(input logic [63:0] d);
        return {d[15:0], d[31:16], d[47:32], d[63:48]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: called at a negedge with inputs set; RAM returns, observe, scoreboard, advance.
    task automatic tick();
        ret_t r;
        if (ram_en) begin
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                data_valid = 1'b1;
                data       = ret_q[0].d;
                void'(ret_q.pop_front());
            end else begin
                data_valid = 1'b0;
                data       = '0;
            end
        end else begin
            data_valid = man_dv;
            data       = man_data;
        end
        #1;
        check("read_without_slot", {63'b0, read & ~mem_slot}, 64'd0);
        if (word_valid && first_wv < 0) first_wv = cyc;
        if (pop) begin
            if (word_valid) begin
                if (sb_en) begin
                    if (exp_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL sb_extra_word: got %h, want no word (cycle %0d)", word_out, cyc);
                    end else begin
                        check("sb_word", word_out, exp_q.pop_front());
                    end
                end
            end else begin
                check("empty_pop_word_out", word_out, 64'd0);
            end
        end
        if (read) begin
            n_reads++;
            last_addr = addr;
            rd_addrs.push_back(addr);
            if (first_rd < 0) first_rd = cyc;
            if (ram_en) begin
                r.due = cyc + 4;
                r.d   = ramfn(addr);
                ret_q.push_back(r);
                if (!frame_start) exp_q.push_back(reorder(ramfn(addr)));
            end
        end
        if (frame_start) exp_q.delete();
        @(posedge pclk);
        @(negedge pclk);
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic fstart(input bit hm);
        himem       = hm;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{64'h1111_2222_3333_4444, 64'h4444_3333_2222_1111};
        vecs[1] = '{64'h0123_4567_89AB_CDEF, 64'hCDEF_89AB_4567_0123};
        vecs[2] = '{64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF};
        vecs[3] = '{64'h8000_0000_0000_0001, 64'h0001_0000_0000_8000};

        reset_n = 1'b0; himem = 1'b0; frame_start = 1'b0; mem_slot = 1'b1;
        pop = 1'b0; data_valid = 1'b0; data = '0;
        @(negedge pclk);
        #1;
        check("rst_addr", 64'(addr), 64'h600000);
        check("rst_read", 64'(read), 64'd0);
        check("rst_word_valid", 64'(word_valid), 64'd0);
        check("rst_level", 64'(level), 64'd0);
        check("rst_underrun", 64'(underrun), 64'd0);
        @(negedge pclk);
        mem_slot = 1'b0;
        reset_n  = 1'b1;
        idle(2);

        // Slot every 16 cycles, no pops: credit stops issue at 8.
        n_reads = 0; rd_addrs.delete(); first_rd = -1; first_wv = -1;
        fstart(1'b0);
        for (int i = 0; i < 200; i++) begin
            mem_slot = (i % 16 == 0);
            tick();
        end
        mem_slot = 1'b0;
        check("credit_reads", 64'(n_reads), 64'd8);
        for (int i = 0; i < rd_addrs.size() && i < 8; i++)
            check("read_addr_seq", 64'(rd_addrs[i]), 64'(23'h600000 + 23'(4 * i)));
        check("credit_level", 64'(level), 64'd8);
        check("first_word_latency", 64'(first_wv - first_rd), 64'd5);
        pop = 1'b1; idle(8); pop = 1'b0;
        check("drain_level", 64'(level), 64'd0);
        check("drain_valid", 64'(word_valid), 64'd0);

        // Manual returns: stray data_valid ignored, then reorder vectors.
        ram_en = 1'b0; sb_en = 1'b0;
        man_dv = 1'b1; man_data = 64'hDEAD_BEEF_0000_0001; tick(); man_dv = 1'b0; tick();
        check("stray_dv_ignored", 64'(level), 64'd0);
        for (int i = 0; i < 4; i++) begin
            mem_slot = 1'b1; tick(); mem_slot = 1'b0;
            idle(2);
            man_dv = 1'b1; man_data = vecs[i].d; tick(); man_dv = 1'b0;
            check("reorder_word", word_out, vecs[i].exp);
            check("reorder_level", 64'(level), 64'd1);
            pop = 1'b1; tick(); pop = 1'b0;
            check("reorder_popped", 64'(level), 64'd0);
        end
        ram_en = 1'b1; sb_en = 1'b1;

        // Level 3, return and pop land in the same cycle.
        fstart(1'b0);
        for (int i = 0; i < 3; i++) begin mem_slot = 1'b1; tick(); mem_slot = 1'b0; end
        idle(6);
        check("pp_pre_level", 64'(level), 64'd3);
        mem_slot = 1'b1; tick(); mem_slot = 1'b0;
        idle(3);
        pop = 1'b1; tick(); pop = 1'b0;
        check("pp_level_kept", 64'(level), 64'd3);
        pop = 1'b1; idle(3); pop = 1'b0;
        check("pp_drained", 64'(level), 64'd0);

        // Underrun on empty pops, cleared by frame_start.
        pop = 1'b1; tick(); pop = 1'b0;
        check("underrun_set", 64'(underrun), 64'd1);
        pop = 1'b1; idle(2); pop = 1'b0;
`ifdef VIKING_UNDERRUN_CNT_EN
        check("underrun_cnt3", 64'(underrun_cnt), 64'd3);
`endif
        fstart(1'b0);
        check("underrun_cleared", 64'(underrun), 64'd0);
`ifdef VIKING_UNDERRUN_CNT_EN
        check("underrun_cnt_kept", 64'(underrun_cnt), 64'd3);
`endif

        // Two reads in flight, new frame at himem base: stale returns must vanish.
        mem_slot = 1'b1; idle(2); mem_slot = 1'b0;
        rd_addrs.delete();
        fstart(1'b1);
        mem_slot = 1'b1; tick(); mem_slot = 1'b0;
        idle(10);
        check("drop_read_count", 64'(rd_addrs.size()), 64'd1);
        if (rd_addrs.size() > 0) check("drop_new_addr", 64'(rd_addrs[0]), 64'h740000);
        check("drop_level", 64'(level), 64'd1);
        check("drop_first_word", word_out, reorder(ramfn(23'h740000)));
        pop = 1'b1; tick(); pop = 1'b0;

        // Whole frame with pops whenever a word is present.
        himem = 1'b0;
        fstart(1'b0);
        n_reads = 0;
        mem_slot = 1'b1;
        for (int k = 0; k < 30000 && n_reads < 20480; k++) begin
            pop = word_valid;
            tick();
        end
        for (int k = 0; k < 20; k++) begin
            pop = word_valid;
            tick();
        end
        pop = 1'b0; mem_slot = 1'b0;
        check("frame_reads", 64'(n_reads), 64'd20480);
        check("frame_last_addr", 64'(last_addr), 64'h613FFC);
        check("frame_no_underrun", 64'(underrun), 64'd0);
        check("frame_sb_empty", 64'(exp_q.size()), 64'd0);
        check("frame_level", 64'(level), 64'd0);

        // Asynchronous reset mid-frame.
        fstart(1'b0);
        pop = 1'b1; tick(); pop = 1'b0;
        mem_slot = 1'b1; idle(10);
        reset_n = 1'b0;
        #1;
        check("midrst_addr", 64'(addr), 64'h600000);
        check("midrst_read", 64'(read), 64'd0);
        check("midrst_word_valid", 64'(word_valid), 64'd0);
        check("midrst_level", 64'(level), 64'd0);
        check("midrst_underrun", 64'(underrun), 64'd0);
        check("midrst_word_out", word_out, 64'd0);
`ifdef VIKING_UNDERRUN_CNT_EN
        check("midrst_cnt", 64'(underrun_cnt), 64'd0);
`endif
        mem_slot = 1'b0;
        @(negedge pclk);
        reset_n = 1'b1;
        @(negedge pclk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
